// File: rtl/audio_sample_sink_pkg.sv
// audio_sample_sink_pkg: shared audio widths and serializer state encoding
package audio_sample_sink_pkg;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_BITS = 32;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
endpackage

// File: rtl/sample_frame_serializer.sv
// sample_frame_serializer: shifts {sample, sample} out MSB first as a left-justified 2x16-bit frame
module sample_frame_serializer
  import audio_sample_sink_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] load_data,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                busy,
  output logic                done
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  ser_state_t state, state_nx;
  logic [DW-1:0] div;
  logic [BW-1:0] bitn;
  logic [FRAME_BITS-1:0] sh;
  logic phase, div_end;
  assign div_end = div == DW'(BCLK_DIV - 1);
  assign busy = state == SHIFT;
  assign done = busy && phase && div_end && bitn == BW'(FRAME_BITS - 1);
  assign bclk = busy & phase;
  assign lrclk = busy & bitn[BW-1];
  assign sdata = busy & sh[FRAME_BITS-1];
  always_comb begin
    state_nx = state;
    state_nx = load ? SHIFT : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // phase is the bclk level; a bit period ends when the high half expires
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      phase <= 1'b0;
      bitn <= '0;
      sh <= '0;
    end else if (load) begin
      div <= '0;
      phase <= 1'b0;
      bitn <= '0;
      sh <= {load_data, load_data};
    end else if (busy) begin
      div <= div_end ? '0 : div + 1'b1;
      if (div_end) phase <= ~phase;
      if (div_end && phase) begin
        bitn <= bitn + 1'b1;
        sh <= sh << 1;
      end
    end
  end
endmodule

// File: rtl/audio_sample_sink.sv
// audio_sample_sink: sample-rate pacer, delayed capture and serial frame output with overrun detect
module audio_sample_sink
  import audio_sample_sink_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 2083,
  parameter int CAPTURE_DELAY = 2,
  parameter int BCLK_DIV = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                new_sample_ready,
  output logic [SAMPLE_W-1:0] held_sample,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_busy,
  output logic                overrun_err
);
  localparam int PW = $clog2(CLKS_PER_SAMPLE);
  localparam int CW = $clog2(CAPTURE_DELAY + 1);
  logic [PW-1:0] pcnt;
  logic [CW-1:0] dcnt;
  logic [SAMPLE_W-1:0] hold;
  logic pending, capture, load, done;
  assign capture = dcnt == CW'(1);
  assign held_sample = hold;
  // at frame end a pending sample goes out first, so a same-cycle capture just refills hold
  assign load = (capture && (!frame_busy || done)) || (done && pending);
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      new_sample_ready <= 1'b0;
      dcnt <= '0;
      hold <= '0;
      pending <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      pcnt <= pcnt == PW'(CLKS_PER_SAMPLE - 1) ? '0 : pcnt + 1'b1;
      new_sample_ready <= pcnt == PW'(CLKS_PER_SAMPLE - 1);
      dcnt <= new_sample_ready ? CW'(CAPTURE_DELAY) : dcnt != '0 ? dcnt - 1'b1 : dcnt;
      if (capture) hold <= sample_in;
      if (done && pending) pending <= capture;
      else if (capture && frame_busy && !done) begin
        pending <= 1'b1;
        if (pending) overrun_err <= 1'b1;
      end
    end
  end
  sample_frame_serializer #(.BCLK_DIV(BCLK_DIV)) u_ser (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_data(done && pending ? hold : sample_in),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .busy(frame_busy),
    .done(done)
  );
endmodule

// File: tb/tb_audio_sample_sink.sv
// tb_audio_sample_sink: directed checks of pacing, capture, frame format, overrun and mid-frame reset
module tb_audio_sample_sink;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] sample_in = '0, sample_in2 = '0;
  logic nsr, bclk, lrclk, sdata, busy, ovr;
  logic nsr2, bclk2, lrclk2, sdata2, busy2, ovr2;
  logic [15:0] held, held2;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] bits, lrs;
  int edges, busy_n;
  always #5 clk = ~clk;
  audio_sample_sink #(.CLKS_PER_SAMPLE(200), .CAPTURE_DELAY(2), .BCLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .new_sample_ready(nsr),
    .held_sample(held), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_busy(busy), .overrun_err(ovr)
  );
  audio_sample_sink #(.CLKS_PER_SAMPLE(100), .CAPTURE_DELAY(2), .BCLK_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .sample_in(sample_in2), .new_sample_ready(nsr2),
    .held_sample(held2), .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2),
    .frame_busy(busy2), .overrun_err(ovr2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go(input int t);
    repeat (t - cyc) @(negedge clk);
    cyc = t;
  endtask
  // records sdata/lrclk at each bclk rising edge over n cycles, and counts busy cycles
  task automatic frame(input bit second, input int n, output logic [31:0] b, output logic [31:0] l,
                       output int e, output int bn);
    logic prev, bc;
    prev = 1'b0; b = '0; l = '0; e = 0; bn = 0;
    for (int i = 0; i < n; i++) begin
      bc = second ? bclk2 : bclk;
      if (bc && !prev) begin
        b = {b[30:0], second ? sdata2 : sdata};
        l = {l[30:0], second ? lrclk2 : lrclk};
        e++;
      end
      if (second ? busy2 : busy) bn++;
      prev = bc;
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    repeat (5) @(negedge clk);
    chk("rst_strobe", nsr, 0);
    chk("rst_held", held, 0);
    chk("rst_serial", {bclk, lrclk, sdata, busy}, 0);
    chk("rst_overrun", {ovr, ovr2}, 0);
    reset = 1'b0; cyc = 0;
    go(199); chk("strobe_199", nsr, 0);
    go(200); chk("strobe_200", nsr, 1);
    go(201); chk("strobe_201", nsr, 0);
    sample_in = 16'h1234;
    go(202); chk("held_before_cap", held, 16'h0000);
    go(203); chk("held_after_cap", held, 16'h1234);
    chk("frame_start", {busy, bclk, sdata}, 3'b100);
    sample_in = 16'h5555;
    frame(1'b0, 140, bits, lrs, edges, busy_n);
    chk("frame_bits", bits, 32'h12341234);
    chk("frame_lrclk", lrs, 32'h0000ffff);
    chk("frame_edges", edges, 32);
    chk("frame_busy_len", busy_n, 128);
    chk("held_no_late_change", held, 16'h1234);
    sample_in = 16'h8001;
    go(402); chk("held_neg_before", held, 16'h1234);
    go(403); chk("held_neg_after", held, 16'h8001);
    frame(1'b0, 140, bits, lrs, edges, busy_n);
    chk("neg_frame_bits", bits, 32'h80018001);
    chk("neg_busy_len", busy_n, 128);
    go(599); chk("strobe_599", nsr, 0);
    go(600); chk("strobe_600", nsr, 1);
    go(601); chk("strobe_601", nsr, 0);
    go(645); chk("bit10_busy_bclk", {busy, bclk}, 2'b11);
    reset = 1'b1;
    go(646); chk("midreset_serial", {bclk, lrclk, sdata, busy}, 0);
    chk("midreset_held", held, 0);
    go(648);
    reset = 1'b0; cyc = 0;
    go(199); chk("restart_199", {nsr, busy}, 0);
    go(200); chk("restart_200", nsr, 1);
    reset = 1'b1;
    sample_in2 = 16'h1111;
    repeat (3) @(negedge clk);
    reset = 1'b0; cyc = 0;
    go(103); chk("ovr_frame1", {busy2, ovr2}, 2'b10);
    go(150); sample_in2 = 16'h2222;
    go(203); chk("ovr_pending_only", ovr2, 0);
    go(250); sample_in2 = 16'h3333;
    go(302); chk("ovr_302", ovr2, 0);
    go(303); chk("ovr_303", ovr2, 1);
    go(358); chk("chain_last", busy2, 1);
    go(359); chk("chain_next", {busy2, bclk2}, 2'b10);
    frame(1'b1, 256, bits, lrs, edges, busy_n);
    chk("chain_bits", bits, 32'h33333333);
    chk("chain_busy_len", busy_n, 256);
    chk("ovr_sticky", ovr2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_sample_sink.md
# audio_sample_sink

Sample-rate pacer and serial output stage on the consumer side of the synth voice interface. It issues the `new_sample_ready` strobe that paces `chords` and the other sample generators, captures their signed 16-bit output a fixed delay after each strobe, and shifts each captured sample out as a left-justified 2×16-bit mono-duplicated serial frame toward the codec pins. It sits between the voice/mixer path and the board audio interface.

## Interface
- `CLKS_PER_SAMPLE`, 2083: clk cycles per sample period (100 MHz / 48 kHz).
- `CAPTURE_DELAY`, 2: cycles from strobe to sample capture. Must be ≥1.
- `BCLK_DIV`, 16: clk cycles per bclk half-period. Must be ≥1. Frame length = 64·`BCLK_DIV` cycles.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `sample_in` in 16: signed sample from the generator/mixer (e.g. `chords_sample`).
- `new_sample_ready` out 1: one-cycle strobe, one per sample period.
- `held_sample` out 16: last captured sample, signed.
- `bclk` out 1: serial bit clock.
- `lrclk` out 1: channel select; 0 = left, 1 = right.
- `sdata` out 1: serial data, MSB first.
- `frame_busy` out 1: high while a frame is shifting.
- `overrun_err` out 1: sticky; cleared only by reset.

## Operation
- **Pacer**
  - Period counter `pcnt` counts 0..`CLKS_PER_SAMPLE`-1, then wraps.
  - `new_sample_ready` = 1 exactly in cycles where `pcnt` == `CLKS_PER_SAMPLE`-1.
- **Capture**
  - Capture cycle = `CAPTURE_DELAY` cycles after the strobe cycle, implemented with a down-counter loaded on the strobe.
  - In the capture cycle, `sample_in` is registered into `held_sample` and into the holding register `hold`.
- **Serializer FSM**
  - IDLE → SHIFT on a capture, when IDLE.
  - On a capture while in SHIFT: set `pending`. If `pending` was already set, set `overrun_err` and overwrite `hold`; the older sample is lost.
  - SHIFT → IDLE at frame end if `pending` = 0.
  - SHIFT → SHIFT (new frame loaded from `hold`, `pending` cleared) at frame end if `pending` = 1.
- **Frame format**
  - Shift register loaded with {`hold`, `hold`}.
  - Bit periods 0–15: left channel, `lrclk` = 0. Bit periods 16–31: right channel, `lrclk` = 1.
  - Each bit period is 2·`BCLK_DIV` cycles:
    - `bclk` is low for the first `BCLK_DIV` cycles and high for the second.
    - `sdata` changes only at the start of a bit period, i.e. on the falling edge, and is stable across the `bclk` rising edge.
  - Samples are two's complement, passed through unmodified with no scaling or saturation.
- **IDLE outputs**: `bclk` = 0, `lrclk` = 0, `sdata` = 0, `frame_busy` = 0.

## Timing
- **Reset values**: `pcnt` = 0, strobe = 0, `held_sample` = 0, `hold` = 0, `pending` = 0, `overrun_err` = 0, FSM = IDLE, all serial outputs 0.
- **First strobe**: in the `CLKS_PER_SAMPLE`-th cycle after the cycle in which `reset` is sampled low.
- **Capture**: `held_sample` shows the new value in the cycle after the capture cycle.
- **Frame start**: first cycle after the capture cycle.
  - `frame_busy` = 1, `sdata` = bit 15 of `hold`, `bclk` = 0.
  - Frame lasts exactly 64·`BCLK_DIV` cycles.
- **Pending start**: the chained frame starts in the cycle immediately after the last cycle of the previous frame, with no idle gap.
- **Capture and frame end in the same cycle**: the frame end moves `hold` into the shifter first. The new capture then goes to `hold` with `pending` = 1, and no overrun is flagged.
- **Reset mid-frame**: outputs return to IDLE values in the next cycle. The frame is abandoned and the capture down-counter is cleared.
- **Default parameters**: frame (1024 cycles) plus delay (2) < period (2083), so overrun never occurs.

## Structure
- Shared audio package holds:
  - the sample width constant (16);
  - the frame bit count (32);
  - the serializer state encoding (IDLE, SHIFT).
- Natural sub-module: `sample_frame_serializer`. It owns the shifter, bclk divider, bit counter and `lrclk`, and exposes `load`, `load_data`, `busy` and `done`.
- The top level owns the pacer, capture delay, `hold`/`pending` and the overrun logic.

## Test plan
Parameters unless stated: `CLKS_PER_SAMPLE` = 200, `CAPTURE_DELAY` = 2, `BCLK_DIV` = 2.
- **Reset**: hold `reset` 5 cycles → all outputs 0. Release → first strobe at cycle 200 after release, then every 200 cycles, each exactly 1 cycle wide.
- **Capture**: change `sample_in` to 16'h1234 one cycle after a strobe → `held_sample` = 16'h1234 three cycles after the strobe. Change `sample_in` after the capture cycle → no effect until the next period.
- **Serial frame**: `sample_in` = 16'h1234 → sample `sdata` on 32 `bclk` rising edges to get 32'h12341234. `lrclk` is 0 for edges 1–16 and 1 for edges 17–32. `frame_busy` is high for exactly 128 cycles.
- **Negative sample**: `sample_in` = 16'h8001 (−32767) → frame bits 32'h80018001, with no sign alteration.
- **Overrun**: `CLKS_PER_SAMPLE` = 100, `BCLK_DIV` = 4 (frame 256 cycles).
  - Capture at cycle 102 → frame starts.
  - Capture at cycle 202 → `pending` set.
  - Capture at cycle 302 → `overrun_err` = 1 from cycle 303 and held until reset.
  - The next frame carries the cycle-302 sample.
- **Reset mid-frame**: assert `reset` at bit 10 → the next cycle shows `bclk`, `lrclk`, `sdata`, `frame_busy` = 0. After release, the pacer restarts with its first strobe at cycle 200.
